fence_sequencer: RTL and testbench
==================================

# fence_sequencer

Memory-stage controller that sequences `fence.i` and `sfence.vma`. It drains the LSU, then drives the D$ flush, I$ invalidate or TLB flush handshakes in order. While the sequence runs it holds a stall cause into the hazard unit, and it pulses completion when the instruction may retire. It sits beside the hazard unit: its `FenceStallM` is ORed into the M-stage stall cause, and it observes the resulting `StallM`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles a cache handshake may wait before abort. Only used when the timeout feature is compiled in.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset; asynchronous, active-low.
- `FenceIM`, in, 1: `fence.i` is valid in M; held while M is stalled.
- `SFenceVmaM`, in, 1: `sfence.vma` is valid in M; never asserted together with `FenceIM`.
- `TrapM`, in, 1: trap in M; blocks the start of a sequence.
- `StallM`, in, 1: final M stall from the hazard unit.
- `LSUIdleM`, in, 1: LSU and store buffer are empty.
- `DCacheFlushReq`, out, 1: D$ writeback-all request.
- `DCacheFlushAck`, in, 1: one-cycle D$ done.
- `ICacheInvReq`, out, 1: I$ invalidate-all request.
- `ICacheInvAck`, in, 1: one-cycle I$ done.
- `TLBFlushM`, out, 1: one-cycle TLB flush pulse.
- `FenceStallM`, out, 1: stall cause to the hazard unit.
- `FenceDoneM`, out, 1: one-cycle completion pulse.
- `FenceTimeoutM`, out, 1: one-cycle abort pulse; exists only with `FENCE_TIMEOUT_EN`.

## Operation
- **Start** = `(FenceIM | SFenceVmaM) & ~TrapM`, sampled in IDLE only. The operation kind is registered at start.
- **States:** IDLE, DRAIN, DCFLUSH, ICINV, TLBFLUSH, DONE.
- **Transitions:**
  - IDLE -> DRAIN on Start.
  - DRAIN -> DCFLUSH for `fence.i`, or -> TLBFLUSH for `sfence.vma`, when `LSUIdleM`.
  - DCFLUSH -> ICINV on `DCacheFlushAck`.
  - ICINV -> DONE on `ICacheInvAck`.
  - TLBFLUSH -> DONE unconditionally, after one cycle.
  - DONE -> IDLE when `~StallM`. While `StallM` is high it stays in DONE, which prevents re-triggering on the same instruction.
- **Outputs:**
  - `FenceStallM = Start | (state ∉ {IDLE, DONE})`. This is combinational, so the fence cannot advance in its first cycle.
  - `DCacheFlushReq` = state is DCFLUSH; `ICacheInvReq` = state is ICINV. Both are registered state decodes.
  - `TLBFlushM` = state is TLBFLUSH.
  - `FenceDoneM` = state is DONE and the previous state was not DONE. It is a single pulse even if DONE is held.
- **Handshakes:**
  - A Req stays high until its Ack is sampled, then drops the following cycle.
  - An Ack arriving while its Req is low is ignored.
  - An Ack in the same cycle the Req first rises is accepted.
- **Traps:**
  - `TrapM` in IDLE suppresses Start.
  - `TrapM` after Start is ignored: cache and TLB operations are not abortable, and the sequence runs to DONE.
- **Reset:** `reset_n` low at any point forces IDLE and clears every output to 0, including a held Req.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Minimum stall for `fence.i`** (LSU idle, immediate Acks), 4 cycles:
  - c0: Start.
  - c1: DRAIN.
  - c2: DCFLUSH, Ack.
  - c3: ICINV, Ack.
  - c4: DONE; `FenceStallM` is 0 and `FenceDoneM` is 1.
- **Minimum stall for `sfence.vma`:** 3 cycles (c0 Start, c1 DRAIN, c2 TLBFLUSH, c3 DONE).
- **Each cycle of wait adds one stall cycle:** every cycle `LSUIdleM` stays low, and every cycle of Ack latency.

## Configuration
- **`FENCE_TIMEOUT_EN` defined:**
  - A counter clears on entry to DCFLUSH or ICINV and increments each cycle spent waiting there.
  - When it reaches `TIMEOUT_CYCLES-1` without an Ack, the FSM drops the Req and goes to DONE.
  - `FenceTimeoutM` pulses in the same cycle as that `FenceDoneM`.
- **Undefined:** no counter and no `FenceTimeoutM` port; the FSM waits for the Ack indefinitely.

## Structure
- **Shared package:**
  - `fence_state_t`, an enum of the six states.
  - `fence_kind_t`, FENCEI or SFENCEVMA.
- **Sub-module:** `fence_watchdog`, compiled only under `FENCE_TIMEOUT_EN`. It contains the counter and emits `expired`, with width `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- **`fence.i` with LSU idle and immediate Acks:**
  - `FenceStallM` is high for exactly 4 cycles.
  - `DCacheFlushReq` is high in c2 and `ICacheInvReq` in c3.
  - `FenceDoneM` pulses once in c4.
- **`sfence.vma` with `LSUIdleM` low for 3 cycles:**
  - DRAIN is held 3 extra cycles.
  - `TLBFlushM` pulses once and no cache Req rises.
  - Total stall is 6 cycles.
- **Start gating and stray Acks:**
  - `FenceIM` together with `TrapM` in c0: no Start, `FenceStallM` stays 0.
  - `ICacheInvAck` pulsed during DCFLUSH is ignored.
- **Held DONE:**
  - Drive `StallM` high for 5 cycles while in DONE.
  - The FSM stays in DONE, `FenceDoneM` pulses only once, and no second sequence starts.
- **Reset mid-operation:**
  - `reset_n` asserted low mid-DCFLUSH with `DCacheFlushReq` high.
  - All outputs go to 0 immediately; after release the FSM is IDLE.
- **Timeout** (`FENCE_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, no Ack):
  - `DCacheFlushReq` is high for 8 cycles, then DONE.
  - `FenceTimeoutM` and `FenceDoneM` pulse together.

Source files
------------

// File: rtl/fence_sequencer_pkg.sv
// Shared types for the fence.i / sfence.vma sequencer: FSM states, operation kind
// and the "sequence in flight" decode used for the hazard-unit stall cause.
package fence_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_DCFLUSH  = 3'd2,
    ST_ICINV    = 3'd3,
    ST_TLBFLUSH = 3'd4,
    ST_DONE     = 3'd5
  } fence_state_t;

  typedef enum logic {
    FENCEI    = 1'b0,
    SFENCEVMA = 1'b1
  } fence_kind_t;

  // DONE is deliberately excluded so the instruction can retire while it is held there.
  function automatic logic is_busy(input fence_state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/fence_watchdog.sv
// Handshake wait counter for the fence sequencer; only present when FENCE_TIMEOUT_EN is defined.
`ifdef FENCE_TIMEOUT_EN
module fence_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_run,
  output logic expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_run) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = i_run & (r_cnt == LIMIT);

endmodule
`endif

// File: rtl/fence_sequencer.sv
// Memory-stage fence.i / sfence.vma sequencer: drain LSU, then D$ flush + I$ invalidate or TLB flush.
// Optional handshake abort is compiled in with FENCE_TIMEOUT_EN.
module fence_sequencer
  import fence_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic FenceIM,
  input  logic SFenceVmaM,
  input  logic TrapM,
  input  logic StallM,
  input  logic LSUIdleM,
  output logic DCacheFlushReq,
  input  logic DCacheFlushAck,
  output logic ICacheInvReq,
  input  logic ICacheInvAck,
  output logic TLBFlushM,
  output logic FenceStallM,
`ifdef FENCE_TIMEOUT_EN
  output logic FenceTimeoutM,
`endif
  output logic FenceDoneM
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fence_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  fence_state_t r_state;
  fence_kind_t  r_kind;
  logic         r_dreq;
  logic         r_ireq;
  logic         r_tlb;
  logic         r_done;
  logic         w_start;
  logic         w_expired;

  // Gated by reset_n so the stall cause is also forced low while reset is held.
  assign w_start     = reset_n & (r_state == ST_IDLE) & (FenceIM | SFenceVmaM) & ~TrapM;
  assign FenceStallM = w_start | is_busy(r_state);

`ifdef FENCE_TIMEOUT_EN
  logic w_wd_run;
  logic w_wd_clr;
  logic r_timeout;

  assign w_wd_run = (r_state == ST_DCFLUSH) | (r_state == ST_ICINV);
  assign w_wd_clr = ~w_wd_run
                  | ((r_state == ST_DCFLUSH) & DCacheFlushAck)
                  | ((r_state == ST_ICINV) & ICacheInvAck);

  fence_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_wd_clr),
    .i_run   (w_wd_run),
    .expired (w_expired)
  );

  // Abort pulse: an Ack arriving on the expiry cycle still wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expired & ~w_wd_clr;
    end
  end

  assign FenceTimeoutM = r_timeout;
`else
  assign w_expired = 1'b0;
`endif

  // Sequencer FSM; Req/flush/done outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_kind  <= FENCEI;
      r_dreq  <= 1'b0;
      r_ireq  <= 1'b0;
      r_tlb   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tlb  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_DRAIN;
            r_kind  <= FenceIM ? FENCEI : SFENCEVMA;
          end
        end
        ST_DRAIN: begin
          if (LSUIdleM) begin
            if (r_kind == FENCEI) begin
              r_state <= ST_DCFLUSH;
              r_dreq  <= 1'b1;
            end else begin
              r_state <= ST_TLBFLUSH;
              r_tlb   <= 1'b1;
            end
          end
        end
        ST_DCFLUSH: begin
          if (DCacheFlushAck) begin
            r_state <= ST_ICINV;
            r_dreq  <= 1'b0;
            r_ireq  <= 1'b1;
          end else if (w_expired) begin
            r_state <= ST_DONE;
            r_dreq  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_ICINV: begin
          if (ICacheInvAck || w_expired) begin
            r_state <= ST_DONE;
            r_ireq  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_TLBFLUSH: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          // Holding here while M is stalled keeps the same fence from restarting.
          if (!StallM) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_dreq  <= 1'b0;
          r_ireq  <= 1'b0;
        end
      endcase
    end
  end

  assign DCacheFlushReq = r_dreq;
  assign ICacheInvReq   = r_ireq;
  assign TLBFlushM      = r_tlb;
  assign FenceDoneM     = r_done;

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed, table-driven bench for fence_sequencer; the timeout rows are included under FENCE_TIMEOUT_EN.
module tb_fence_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic FenceIM = 1'b0, SFenceVmaM = 1'b0, TrapM = 1'b0, StallM = 1'b0, LSUIdleM = 1'b0;
  logic DCacheFlushAck = 1'b0, ICacheInvAck = 1'b0;
  logic DCacheFlushReq, ICacheInvReq, TLBFlushM, FenceStallM, FenceDoneM;
  logic FenceTimeoutM;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fence_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .FenceIM        (FenceIM),
    .SFenceVmaM     (SFenceVmaM),
    .TrapM          (TrapM),
    .StallM         (StallM),
    .LSUIdleM       (LSUIdleM),
    .DCacheFlushReq (DCacheFlushReq),
    .DCacheFlushAck (DCacheFlushAck),
    .ICacheInvReq   (ICacheInvReq),
    .ICacheInvAck   (ICacheInvAck),
    .TLBFlushM      (TLBFlushM),
    .FenceStallM    (FenceStallM),
`ifdef FENCE_TIMEOUT_EN
    .FenceTimeoutM  (FenceTimeoutM),
`endif
    .FenceDoneM     (FenceDoneM)
  );

`ifndef FENCE_TIMEOUT_EN
  assign FenceTimeoutM = 1'b0;
`endif

  // One clock cycle: inputs {FenceIM,SFenceVmaM,TrapM,StallM,LSUIdleM,DAck,IAck},
  // expected {FenceStallM,DCacheFlushReq,ICacheInvReq,TLBFlushM,FenceDoneM,FenceTimeoutM}.
  typedef struct {
    string      tag;
    logic [6:0] in;
    logic [5:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [5:0] ex);
    chk({nm, " FenceStallM"},    FenceStallM,    ex[5]);
    chk({nm, " DCacheFlushReq"}, DCacheFlushReq, ex[4]);
    chk({nm, " ICacheInvReq"},   ICacheInvReq,   ex[3]);
    chk({nm, " TLBFlushM"},      TLBFlushM,      ex[2]);
    chk({nm, " FenceDoneM"},     FenceDoneM,     ex[1]);
`ifdef FENCE_TIMEOUT_EN
    chk({nm, " FenceTimeoutM"},  FenceTimeoutM,  ex[0]);
`endif
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    {FenceIM, SFenceVmaM, TrapM, StallM, LSUIdleM, DCacheFlushAck, ICacheInvAck} = v.in;
    #1;
    chk_all(v.tag, v.ex);
  endtask

  task automatic add(input string tag, input logic [6:0] in, input logic [5:0] ex);
    vec_t v;
    v.tag = tag;
    v.in  = in;
    v.ex  = ex;
    tbl.push_back(v);
  endtask

  initial begin
    // fence.i, LSU idle, immediate Acks: 4 stall cycles, Done in c4
    add("fi.c0", 7'b1001100, 6'b100000);
    add("fi.c1", 7'b1001100, 6'b100000);
    add("fi.c2", 7'b1001110, 6'b110000);
    add("fi.c3", 7'b1001101, 6'b101000);
    add("fi.c4", 7'b1000100, 6'b000010);
    add("fi.c5", 7'b0000100, 6'b000000);
    // sfence.vma with LSU busy for 3 DRAIN cycles: 6 stall cycles
    add("sf.c0", 7'b0101100, 6'b100000);
    add("sf.c1", 7'b0101000, 6'b100000);
    add("sf.c2", 7'b0101000, 6'b100000);
    add("sf.c3", 7'b0101000, 6'b100000);
    add("sf.c4", 7'b0101100, 6'b100000);
    add("sf.c5", 7'b0101100, 6'b100100);
    add("sf.c6", 7'b0100100, 6'b000010);
    add("sf.c7", 7'b0000100, 6'b000000);
    // trap blocks start
    add("trap.fi",  7'b1010100, 6'b000000);
    add("trap.fi1", 7'b0000100, 6'b000000);
    add("trap.sf",  7'b0110100, 6'b000000);
    add("trap.sf1", 7'b0000100, 6'b000000);
    // stray Acks ignored, one cycle of Ack latency on each cache
    add("stray.c0", 7'b1001100, 6'b100000);
    add("stray.c1", 7'b1001110, 6'b100000);
    add("stray.c2", 7'b1001101, 6'b110000);
    add("stray.c3", 7'b1001110, 6'b110000);
    add("stray.c4", 7'b1001110, 6'b101000);
    add("stray.c5", 7'b1001101, 6'b101000);
    add("stray.c6", 7'b1000100, 6'b000010);
    add("stray.c7", 7'b0000100, 6'b000000);
    // DONE held by StallM for 5 cycles with FenceIM still valid
    add("hold.c0", 7'b1001100, 6'b100000);
    add("hold.c1", 7'b1001100, 6'b100000);
    add("hold.c2", 7'b1001110, 6'b110000);
    add("hold.c3", 7'b1001101, 6'b101000);
    add("hold.c4", 7'b1001100, 6'b000010);
    for (int i = 0; i < 4; i++) add($sformatf("hold.c%0d", 5 + i), 7'b1001100, 6'b000000);
    add("hold.c9",  7'b1000100, 6'b000000);
    add("hold.c10", 7'b0000100, 6'b000000);
`ifdef FENCE_TIMEOUT_EN
    // No D$ Ack: Req held 8 cycles, then Done and Timeout together
    add("to.c0", 7'b1001100, 6'b100000);
    add("to.c1", 7'b1001100, 6'b100000);
    for (int i = 0; i < 8; i++) add($sformatf("to.c%0d", 2 + i), 7'b1001100, 6'b110000);
    add("to.c10", 7'b1000100, 6'b000011);
    add("to.c11", 7'b0000100, 6'b000000);
`endif

    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", 6'b000000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Asynchronous reset in the middle of DCFLUSH with the Req high
    apply('{tag: "rst.c0", in: 7'b1001100, ex: 6'b100000});
    apply('{tag: "rst.c1", in: 7'b1001100, ex: 6'b100000});
    apply('{tag: "rst.c2", in: 7'b1001100, ex: 6'b110000});
    #2 reset_n = 1'b0;
    #1 chk_all("rst.async", 6'b000000);
    @(negedge clk);
    reset_n = 1'b1;
    FenceIM = 1'b0;
    #1 chk_all("rst.release", 6'b000000);
    apply('{tag: "rst.idle",  in: 7'b0000101, ex: 6'b000000});
    apply('{tag: "rst.sf.c0", in: 7'b0101100, ex: 6'b100000});
    apply('{tag: "rst.sf.c1", in: 7'b0101100, ex: 6'b100000});
    apply('{tag: "rst.sf.c2", in: 7'b0101100, ex: 6'b100100});
    apply('{tag: "rst.sf.c3", in: 7'b0100100, ex: 6'b000010});
    apply('{tag: "rst.sf.c4", in: 7'b0000100, ex: 6'b000000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
